dff_pipeline: RTL and testbench

Parametrised positive-edge register pipeline. It generalises the single master-slave D flip-flop into a WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking, global stall, synchronous flush and an occupancy count. It sits between HACK datapath blocks (ALU result, A/D register write-back, memory address path) wherever a fixed-latency, stallable delay is needed.

---
 rtl/dff_pipeline.sv | 101 ++++++++++
 tb/tb_dff_pipeline.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// dff_pipeline: WIDTH-bit, DEPTH-stage stallable register delay line with
// per-stage valid tracking, synchronous flush and an occupancy count.
// Optional feature macro: DFF_PIPE_NQ_EN adds the nq (complement of q) port.
module dff_pipeline #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             valid_in,
  output logic [WIDTH-1:0] q,
`ifdef DFF_PIPE_NQ_EN
  output logic [WIDTH-1:0] nq,
`endif
  output logic             valid_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] stage_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic             full_r;
  logic             empty_r;

  // Next occupancy: one word in and/or one word out per enabled edge; the
  // exiting valid is the pre-edge last-stage bit, so in+out cancel.
  always_comb begin
    cnt_next_s = cnt_r;
    if (flush) begin
      cnt_next_s = ZERO_C;
    end else if (en) begin
      case ({valid_in, vld_r[DEPTH-1]})
        2'b10:   cnt_next_s = cnt_r + ONE_C;
        2'b01:   cnt_next_s = cnt_r - ONE_C;
        default: cnt_next_s = cnt_r;
      endcase
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Data and valid shift register: flush clears, enable shifts, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
      vld_r <= {DEPTH{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
      vld_r <= {DEPTH{1'b0}};
    end else if (en) begin
      stage_r[0] <= data;
      vld_r[0]   <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
        vld_r[i]   <= vld_r[i-1];
      end
    end else begin
      vld_r <= vld_r;
    end
  end

  // Occupancy count and its full/empty flags, registered so the flags come
  // straight from flops and always agree with the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= ZERO_C;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_next_s;
      full_r  <= (cnt_next_s == DEPTH_C);
      empty_r <= (cnt_next_s == ZERO_C);
    end
  end

  assign q         = stage_r[DEPTH-1];
  assign valid_out = vld_r[DEPTH-1];
  assign count     = cnt_r;
  assign full      = full_r;
  assign empty     = empty_r;

`ifdef DFF_PIPE_NQ_EN
  assign nq = ~stage_r[DEPTH-1];
`endif

endmodule

// File: tb/tb_dff_pipeline.sv
// Self-checking bench for dff_pipeline: a 16-bit/3-stage instance and a
// 1-bit/1-stage instance share control inputs; a history-based model
// predicts every output and a negedge process compares each cycle.
module tb_dff_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en;
  logic        flush;
  logic [15:0] data;
  logic        valid_in;
  logic        data1;
  logic        v1;

  logic [15:0] q3;
  logic        valid_out3;
  logic [1:0]  count3;
  logic        full3;
  logic        empty3;
  logic        q1;
  logic        valid_out1;
  logic [0:0]  count1;
  logic        full1;
  logic        empty1;
`ifdef DFF_PIPE_NQ_EN
  logic [15:0] nq3;
  logic        nq1;
`endif

  int errors = 0;
  int checks = 0;

  dff_pipeline #(.WIDTH(16), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .data(data), .valid_in(valid_in), .q(q3),
`ifdef DFF_PIPE_NQ_EN
    .nq(nq3),
`endif
    .valid_out(valid_out3), .count(count3), .full(full3), .empty(empty3)
  );

  dff_pipeline #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .data(data1), .valid_in(v1), .q(q1),
`ifdef DFF_PIPE_NQ_EN
    .nq(nq1),
`endif
    .valid_out(valid_out1), .count(count1), .full(full1), .empty(empty1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last DEPTH enabled inputs since reset/flush.
  // The output is the oldest of them once DEPTH have been seen, else zero;
  // the count is how many of them were valid.
  typedef struct packed {logic [15:0] d; logic v;} ent_t;
  ent_t h3[$];
  ent_t h1[$];

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      h3.delete();
      h1.delete();
    end else if (en) begin
      h3.push_back({data, valid_in});
      if (h3.size() > 3) void'(h3.pop_front());
      h1.push_back({15'd0, data1, v1});
      if (h1.size() > 1) void'(h1.pop_front());
    end
  end

  function automatic logic [15:0] exp_q3();
    return (h3.size() == 3) ? h3[0].d : 16'h0000;
  endfunction
  function automatic logic exp_v3();
    return (h3.size() == 3) ? h3[0].v : 1'b0;
  endfunction
  function automatic int exp_cnt3();
    int n = 0;
    foreach (h3[i]) n += int'(h3[i].v);
    return n;
  endfunction
  function automatic logic exp_q1();
    return (h1.size() == 1) ? h1[0].d[0] : 1'b0;
  endfunction
  function automatic logic exp_v1();
    return (h1.size() == 1) ? h1[0].v : 1'b0;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("q3",      q3,         exp_q3());
    chk("valid3",  valid_out3, exp_v3());
    chk("count3",  count3,     exp_cnt3());
    chk("full3",   full3,      exp_cnt3() == 3);
    chk("empty3",  empty3,     exp_cnt3() == 0);
    chk("q1",      q1,         exp_q1());
    chk("valid1",  valid_out1, exp_v1());
    chk("count1",  count1,     exp_v1());
    chk("full1",   full1,      exp_v1());
    chk("empty1",  empty1,     !exp_v1());
`ifdef DFF_PIPE_NQ_EN
    chk("nq3",     nq3,        ~exp_q3());
    chk("nq1",     nq1,        ~exp_q1());
`endif
  end

  task automatic cyc(input logic e, input logic f, input logic [15:0] d, input logic v);
    en       = e;
    flush    = f;
    data     = d;
    valid_in = v;
    data1    = ~data1;
    v1       = v;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sent [10];

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0; data = 16'h0000;
    valid_in = 1'b0; data1 = 1'b0; v1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_q",     q3,         16'h0000);
    chk("rst_count", count3,     2'd0);
    chk("rst_empty", empty3,     1'b1);
    chk("rst_full",  full3,      1'b0);
    chk("rst_valid", valid_out3, 1'b0);
`ifdef DFF_PIPE_NQ_EN
    chk("rst_nq",    nq3,        16'hFFFF);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Latency: DEPTH = 3, word visible after the third enabled edge.
    cyc(1'b1, 1'b0, 16'h1234, 1'b1);
    chk("lat_cnt0", count3, 2'd1);
    chk("lat_v0",   valid_out3, 1'b0);
    cyc(1'b1, 1'b0, 16'hAAAA, 1'b0);
    chk("lat_cnt1", count3, 2'd1);
    chk("lat_v1",   valid_out3, 1'b0);
    cyc(1'b1, 1'b0, 16'hBBBB, 1'b0);
    chk("lat_q2",   q3, 16'h1234);
    chk("lat_v2",   valid_out3, 1'b1);
    chk("lat_cnt2", count3, 2'd1);
    cyc(1'b1, 1'b0, 16'hCCCC, 1'b0);
    chk("lat_cnt3", count3, 2'd0);
    chk("lat_emp3", empty3, 1'b1);
    chk("lat_q3",   q3, 16'hAAAA);

    // Stall with C, B, A held; C at the output.
    cyc(1'b1, 1'b0, 16'hC0C0, 1'b1);
    cyc(1'b1, 1'b0, 16'hB0B0, 1'b1);
    cyc(1'b1, 1'b0, 16'hA0A0, 1'b1);
    chk("stall_full", full3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 16'($urandom), 1'b1);
      chk("stall_q",   q3, 16'hC0C0);
      chk("stall_cnt", count3, 2'd3);
    end
    cyc(1'b1, 1'b0, 16'h1111, 1'b0);
    chk("rel_qb",   q3, 16'hB0B0);
    chk("rel_cntb", count3, 2'd2);
    cyc(1'b1, 1'b0, 16'h2222, 1'b0);
    chk("rel_qa",   q3, 16'hA0A0);
    chk("rel_cnta", count3, 2'd1);
    cyc(1'b1, 1'b0, 16'h3333, 1'b0);
    chk("rel_q1",   q3, 16'h1111);
    chk("rel_cnt0", count3, 2'd0);

    // Streaming: full saturation then drain.
    for (int k = 0; k < 10; k++) begin
      sent[k] = 16'($urandom);
      cyc(1'b1, 1'b0, sent[k], 1'b1);
      if (k >= 2) begin
        chk("str_q",    q3, sent[k-2]);
        chk("str_full", full3, 1'b1);
      end
    end
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 1'b0, 16'($urandom), 1'b0);
      chk("drain_cnt", count3, 32'(2 - j));
      if (j < 2) chk("drain_q", q3, sent[8 + j]);
    end
    chk("drain_empty", empty3, 1'b1);

    // Flush beats enable; input discarded.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);
    cyc(1'b1, 1'b1, 16'hDEAD, 1'b1);
    chk("fl_cnt",   count3, 2'd0);
    chk("fl_valid", valid_out3, 1'b0);
    chk("fl_q",     q3, 16'h0000);
    chk("fl_empty", empty3, 1'b1);
    // Flush while stalled still clears.
    cyc(1'b1, 1'b0, 16'h5555, 1'b1);
    cyc(1'b1, 1'b0, 16'h6666, 1'b1);
    cyc(1'b0, 1'b1, 16'h7777, 1'b1);
    chk("fls_cnt", count3, 2'd0);
    cyc(1'b1, 1'b0, 16'h8888, 1'b0);
    cyc(1'b1, 1'b0, 16'h9999, 1'b0);
    chk("fls_q", q3, 16'h0000);

    // Depth-1 corner: q follows toggling data one edge later.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 16'($urandom), 1'b1);
      chk("d1_q", q1, data1);
`ifdef DFF_PIPE_NQ_EN
      chk("d1_nq", nq1, ~data1);
`endif
    end

    // Asynchronous reset mid-cycle with the pipeline full.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 16'hF00D, 1'b1);
    chk("pre_rst_full", full3, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_q",     q3, 16'h0000);
    chk("arst_valid", valid_out3, 1'b0);
    chk("arst_count", count3, 2'd0);
    chk("arst_empty", empty3, 1'b1);
    chk("arst_q1",    q1, 1'b0);
`ifdef DFF_PIPE_NQ_EN
    chk("arst_nq",    nq3, 16'hFFFF);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with occasional flush and mid-cycle reset.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
